// File: rtl/updown_mon_pkg.sv
// Shared types for the up/down counter monitor: step classes and FSM states.
package updown_mon_pkg;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_JUMP
    } step_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/updown_count_monitor_if.sv
// Observation bus between a monitored up/down counter and its monitor.
interface updown_count_monitor_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) ();

    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             dir_up;
    logic             dir_valid;
    logic             locked;
    logic             hold;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en,
        output count_in,
        input  dir_up,
        input  dir_valid,
        input  locked,
        input  hold,
        input  step_err,
        input  err_count
    );

    modport slave (
        input  en,
        input  count_in,
        output dir_up,
        output dir_valid,
        output locked,
        output hold,
        output step_err,
        output err_count
    );

endinterface

// File: rtl/updown_step_classify.sv
// Classifies one sample against the previous one by modular difference.
module updown_step_classify
    import updown_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count_in,
    output step_t            step
);

    logic [WIDTH-1:0] delta;

    // Modular subtraction makes 15->0 a +1 and 0->15 a -1.
    assign delta = count_in - prev;

    always_comb begin
        if (delta == '0) begin
            step = STEP_HOLD;
        end else if (delta == WIDTH'(1)) begin
            step = STEP_UP;
        end else if (delta == '1) begin
            step = STEP_DOWN;
        end else begin
            step = STEP_JUMP;
        end
    end

endmodule

// File: rtl/updown_count_monitor.sv
// Passive monitor: recovers direction and lock from a sampled up/down count stream,
// flags and counts illegal jumps seen while locked.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_count_monitor_if.slave mon
);

    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               cand_q, cand_d;
    logic               dir_up_q, dir_up_d;
    logic               hold_q, hold_d;
    logic               step_err_q, step_err_d;
    logic [ERR_W-1:0]   err_q, err_d;

    step_t              step;
    logic               is_step;
    logic               step_up;
    logic [RUN_W-1:0]   run_next;

    updown_step_classify #(
        .WIDTH(WIDTH)
    ) u_classify (
        .prev    (prev_q),
        .count_in(mon.count_in),
        .step    (step)
    );

    assign is_step = (step == STEP_UP) || (step == STEP_DOWN);
    assign step_up = (step == STEP_UP);

    // A fresh run (run_q == 0) or a same-direction step extends the run; a reversal restarts at 1.
    assign run_next = ((run_q == '0) || (step_up == cand_q)) ? run_q + 1'b1 : RUN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            cand_q     <= 1'b0;
            dir_up_q   <= 1'b0;
            hold_q     <= 1'b0;
            step_err_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            cand_q     <= cand_d;
            dir_up_q   <= dir_up_d;
            hold_q     <= hold_d;
            step_err_q <= step_err_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mon.en) begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (is_step && (run_next == RUN_LOCK)) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (step == STEP_JUMP) state_d = ST_ACQUIRE;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        prev_d     = prev_q;
        run_d      = run_q;
        cand_d     = cand_q;
        dir_up_d   = dir_up_q;
        hold_d     = hold_q;
        step_err_d = 1'b0;
        err_d      = err_q;
        if (mon.en) begin
            prev_d = mon.count_in;
            // The capture sample has no predecessor, so it never reports hold.
            hold_d = (state_q != ST_IDLE) && (step == STEP_HOLD);
            unique case (state_q)
                ST_IDLE:    run_d = '0;
                ST_ACQUIRE: begin
                    if (is_step) begin
                        run_d  = run_next;
                        cand_d = step_up;
                        if (run_next == RUN_LOCK) dir_up_d = step_up;
                    end else if (step == STEP_JUMP) begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_step) begin
                        dir_up_d = step_up;
                    end else if (step == STEP_JUMP) begin
                        step_err_d = 1'b1;
                        run_d      = '0;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end
                end
                default:    run_d = '0;
            endcase
        end
    end

    assign mon.locked    = (state_q == ST_LOCKED);
    assign mon.dir_valid = (state_q == ST_LOCKED);
    assign mon.dir_up    = dir_up_q;
    assign mon.hold      = hold_q;
    assign mon.step_err  = step_err_q;
    assign mon.err_count = err_q;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Scoreboard bench for updown_count_monitor against a behavioural reference model.
module tb_updown_count_monitor;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned ERR_W    = 8;
    localparam int          ERR_MAX  = 255;

    typedef struct {
        bit dir_up;
        bit dir_valid;
        bit locked;
        bit hold;
        bit step_err;
        int err;
    } exp_t;

    logic clk;
    logic reset;

    updown_count_monitor_if #(
        .WIDTH(WIDTH),
        .ERR_W(ERR_W)
    ) bus ();

    updown_count_monitor #(
        .WIDTH   (WIDTH),
        .LOCK_CNT(LOCK_CNT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mon  (bus)
    );

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 = waiting for first sample, 1 = acquiring, 2 = locked.
    int m_mode = 0;
    int m_prev = 0;
    int m_run  = 0;
    bit m_cand = 0;
    bit m_dir  = 0;
    bit m_hold = 0;
    bit m_serr = 0;
    int m_err  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit e, input int c);
        int d;
        m_serr = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_cand = 0;
            m_dir = 0; m_hold = 0; m_err = 0;
        end else if (e) begin
            if (m_mode == 0) begin
                m_prev = c; m_run = 0; m_mode = 1; m_hold = 0;
            end else begin
                d = (c - m_prev + 16) % 16;
                m_prev = c;
                m_hold = (d == 0);
                if (m_mode == 1) begin
                    if (d == 1 || d == 15) begin
                        if (m_run == 0 || (d == 1) == m_cand) m_run = m_run + 1;
                        else m_run = 1;
                        m_cand = (d == 1);
                        if (m_run >= LOCK_CNT) begin
                            m_mode = 2;
                            m_dir  = m_cand;
                        end
                    end else if (d != 0) begin
                        m_run = 0;
                    end
                end else begin
                    if (d == 1 || d == 15) begin
                        m_dir = (d == 1);
                    end else if (d != 0) begin
                        m_serr = 1;
                        if (m_err < ERR_MAX) m_err = m_err + 1;
                        m_mode = 1;
                        m_run  = 0;
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit r, input bit e, input int c);
        exp_t x;
        @(negedge clk);
        reset        = r;
        bus.en       = e;
        bus.count_in = WIDTH'(c);
        model_step(r, e, c % 16);
        x.dir_up    = m_dir;
        x.dir_valid = (m_mode == 2);
        x.locked    = (m_mode == 2);
        x.hold      = m_hold;
        x.step_err  = m_serr;
        x.err       = m_err;
        sbq.push_back(x);
    endtask

    // Monitor: one expected response per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("dir_up",    int'(bus.dir_up),    int'(e.dir_up));
                check("dir_valid", int'(bus.dir_valid), int'(e.dir_valid));
                check("locked",    int'(bus.locked),    int'(e.locked));
                check("hold",      int'(bus.hold),      int'(e.hold));
                check("step_err",  int'(bus.step_err),  int'(e.step_err));
                check("err_count", int'(bus.err_count), e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur;
        int r;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.count_in = '0;

        repeat (5) drive(1, 1, $urandom_range(0, 15));

        // Up-count through wrap, then reverse.
        for (int i = 0; i < 16; i++) drive(0, 1, i);
        drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 1, 15);
        drive(0, 1, 14);
        for (int v = 13; v >= 6; v--) drive(0, 1, v);

        // Jump while locked, then relock.
        drive(0, 1, 11);
        drive(0, 1, 12);
        drive(0, 1, 13);
        drive(0, 1, 14);

        // Down to 7 and hold, then idle with en low.
        for (int v = 13; v >= 7; v--) drive(0, 1, v);
        repeat (4) drive(0, 1, 7);
        repeat (3) drive(0, 0, $urandom_range(0, 15));

        // Counter reset mid-count, relock, then forced jumps to saturation.
        drive(0, 1, 8);
        drive(0, 1, 9);
        drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 1, 2);
        drive(0, 1, 3);
        cur = 3;
        for (int k = 0; k < 260; k++) begin
            cur = (cur + 5) % 16;
            drive(0, 1, cur);
            for (int s = 0; s < 3; s++) begin
                cur = (cur + 1) % 16;
                drive(0, 1, cur);
            end
        end
        @(posedge clk);
        #2;
        check("err_saturated", int'(bus.err_count), ERR_MAX);

        // Randomised mix of legal steps, holds, jumps and en gaps.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       cur = (cur + 1) % 16;
            else if (r < 8)  cur = (cur + 15) % 16;
            else if (r == 9) cur = $urandom_range(0, 15);
            drive(0, ($urandom_range(0, 9) != 0), cur);
        end

        // Lock, then assert reset between edges.
        for (int s = 0; s < 4; s++) begin
            cur = (cur + 1) % 16;
            drive(0, 1, cur);
        end
        @(posedge clk);
        #3;
        check("locked_before_reset", int'(bus.locked), 1);
        reset = 1'b1;
        #1;
        check("async_locked",    int'(bus.locked),    0);
        check("async_dir_valid", int'(bus.dir_valid), 0);
        check("async_dir_up",    int'(bus.dir_up),    0);
        check("async_hold",      int'(bus.hold),      0);
        check("async_step_err",  int'(bus.step_err),  0);
        check("async_err_count", int'(bus.err_count), 0);
        drive(1, 1, 5);
        drive(1, 0, 0);

        // Alternating stream must never lock.
        for (int i = 0; i < 10; i++) drive(0, 1, i % 2);
        drive(0, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_count_monitor.md
# updown_count_monitor

- Passive monitor that samples the 4-bit count of an up/down counter and recovers its behaviour from the value stream.
- Reports the current count direction and whether the stream is locked to legal ±1 steps.
- Flags and counts illegal jumps.
- Sits beside the up/down counter in the same clock domain; feeds status/debug logic and self-checking benches.

## Interface
- WIDTH, 4, width of monitored count
- LOCK_CNT, 3, consecutive same-direction steps required to lock (≥1)
- ERR_W, 8, width of saturating error counter
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  sample enable; count_in is ignored when low
- count_in  in  WIDTH  counter value under observation
- dir_up  out  1  1 = counting up, 0 = counting down; meaningful only when dir_valid
- dir_valid  out  1  direction established (equals locked)
- locked  out  1  stream is following legal steps
- hold  out  1  last enabled sample equalled the previous one
- step_err  out  1  one-cycle pulse on an illegal step while locked
- err_count  out  ERR_W  number of step_err pulses, saturates at all-ones

## Operation
- Step class of each enabled sample relative to prev, computed modulo 2^WIDTH as delta = count_in − prev:
  - delta 0 → HOLD
  - delta 1 → UP
  - delta all-ones → DOWN
  - anything else → JUMP
- Wrap is legal: 15→0 is UP, 0→15 is DOWN.
- Every enabled sample updates prev.
- FSM states are IDLE, ACQUIRE and LOCKED.
  - IDLE: the first enabled sample loads prev; run_len = 0; go to ACQUIRE.
  - ACQUIRE, UP/DOWN matching cand_dir, or run_len = 0: run_len++; cand_dir = class.
  - ACQUIRE, UP/DOWN against cand_dir: run_len = 1; cand_dir = class.
  - ACQUIRE, HOLD: no change to run_len.
  - ACQUIRE, JUMP: run_len = 0; no error.
  - ACQUIRE exit: when run_len reaches LOCK_CNT, go to LOCKED and set dir_up = cand_dir.
  - LOCKED, UP/DOWN: legal. A reversal (the counter's up_down toggling) updates dir_up immediately and stays LOCKED.
  - LOCKED, HOLD: legal.
  - LOCKED, JUMP: pulse step_err, err_count++ (saturating), go to ACQUIRE, run_len = 0.
- Counter being reset mid-count (e.g. 9→0) is a JUMP; while LOCKED it counts as an error. This is intentional.
- en low: FSM, prev, run_len and all outputs hold; step_err is 0.
- Reset asserted mid-operation clears everything asynchronously. err_count is not preserved.

## Timing
- All outputs are registered and take effect on the clk edge that samples the enabled count_in (one-cycle latency).
- Reset values:
  - dir_up = 0, dir_valid = 0, locked = 0, hold = 0, step_err = 0, err_count = 0
  - state = IDLE, prev = 0, run_len = 0
- LOCK_CNT = 3, continuous en: lock is reached on the 4th enabled sample edge (1 capture + 3 steps).
- step_err is high for exactly one cycle per JUMP in LOCKED. locked and dir_valid fall on the same edge.
- hold updates on every enabled sample: 1 for HOLD, 0 otherwise.
- Reset deassertion is synchronous-safe: the first enabled edge after deassertion acts as the IDLE capture.

## Structure
- Package updown_mon_pkg:
  - step-class enum (STEP_HOLD, STEP_UP, STEP_DOWN, STEP_JUMP)
  - state enum (ST_IDLE, ST_ACQUIRE, ST_LOCKED)
- Combinational sub-module updown_step_classify(prev, count_in → step class), parameterised by WIDTH.
- Top level holds the FSM, run_len (width $clog2(LOCK_CNT+1)), prev and the counters.

## Test plan
- Reset held 5 cycles, then up-count 0,1,2,3 with en = 1 → locked = 1, dir_up = 1 after the 4th sample; all outputs 0 while in reset.
- Locked up-count 13,14,15,0,1 → no step_err; then up_down flips (1,0,15,14) → dir_up = 0 on the edge sampling 0, locked stays 1.
- Locked at 6, input jumps to 11 → step_err for one cycle, err_count = 1, locked = 0; relock after 3 further legal steps.
- Count held at 7 for 4 cycles while locked → hold = 1 each cycle, locked stays 1, no error; en low for 3 cycles with random count_in → no output change.
- Counter reset mid-count (locked at 9 → 0) → one error counted; 260 forced jumps with ERR_W = 8 → err_count saturates at 255.
- Monitor reset asserted asynchronously between clk edges while locked → outputs clear immediately; alternating 0,1,0,1 after release never locks.
